// File: rtl/pattern_pkg.sv
// Shared definitions for the pattern input conditioner: input count,
// bit positions of the four pattern inputs and the symbol type.
package pattern_pkg;

  localparam int NUM_INPUTS = 4;

  localparam int SYM_I1 = 0;
  localparam int SYM_I2 = 1;
  localparam int SYM_I3 = 2;
  localparam int SYM_I4 = 3;

  typedef logic [NUM_INPUTS-1:0] symbol_t;

endpackage

// File: rtl/pattern_input_conditioner_debounce_bit.sv
// One input bit: 2-flop synchronizer followed by a mismatch-count debouncer.
// update flags the edge on which stable will take the synchronized level.
module debounce_bit #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic stable,
  output logic level,
  output logic update
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_reg;
  logic          sync2_reg;
  logic          stable_reg;
  logic [CW-1:0] cnt_reg;

  assign stable = stable_reg;
  assign level  = sync2_reg;
  assign update = (sync2_reg != stable_reg) && (cnt_reg == CNT_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_reg  <= 1'b0;
      sync2_reg  <= 1'b0;
      stable_reg <= 1'b0;
      cnt_reg    <= '0;
    end else begin
      sync1_reg <= raw;
      sync2_reg <= sync1_reg;
      if (sync2_reg == stable_reg) begin
        cnt_reg <= '0;
      end else if (cnt_reg == CNT_LAST) begin
        stable_reg <= sync2_reg;
        cnt_reg    <= '0;
      end else begin
        cnt_reg <= cnt_reg + CW'(1);
      end
    end
  end

endmodule

// File: rtl/pattern_input_conditioner.sv
// Debounces four pattern inputs and queues each change of the debounced
// vector as one symbol in a first-word-fall-through buffer.
module pattern_input_conditioner
  import pattern_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [NUM_INPUTS-1:0]             raw_i,
  input  logic                              sym_ready,
  output logic                              sym_valid,
  output logic [NUM_INPUTS-1:0]             sym_data,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count,
  output logic                              overflow
);

  localparam int PW   = $clog2(FIFO_DEPTH);
  localparam int CNTW = $clog2(FIFO_DEPTH + 1);

  symbol_t stable_vec;
  symbol_t level_vec;
  symbol_t update_vec;

  for (genvar gi = 0; gi < NUM_INPUTS; gi++) begin : g_bit
    debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk    (clk),
      .reset  (reset),
      .raw    (raw_i[gi]),
      .stable (stable_vec[gi]),
      .level  (level_vec[gi]),
      .update (update_vec[gi])
    );
  end

  symbol_t         mem [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr_reg;
  logic [PW-1:0]   rd_ptr_reg;
  logic [PW-1:0]   rd_ptr_inc;
  logic [CNTW-1:0] count_reg;
  logic [CNTW-1:0] count_next;
  logic            sym_valid_reg;
  symbol_t         sym_data_reg;
  symbol_t         head_next;
  logic            overflow_reg;

  symbol_t push_data;
  logic    push;
  logic    pop;
  logic    full;
  logic    accept;
  logic    drop;

  assign sym_valid  = sym_valid_reg;
  assign sym_data   = sym_data_reg;
  assign fifo_count = count_reg;
  assign overflow   = overflow_reg;

  always_comb begin
    // Bits updating this edge contribute their new level; all others keep stable.
    push_data  = (stable_vec & ~update_vec) | (level_vec & update_vec);
    push       = |update_vec;
    pop        = sym_valid_reg && sym_ready;
    full       = (count_reg == CNTW'(FIFO_DEPTH));
    accept     = push && (!full || pop);
    drop       = push && full && !pop;
    rd_ptr_inc = rd_ptr_reg + PW'(1);

    count_next = count_reg;
    if (accept && !pop) begin
      count_next = count_reg + CNTW'(1);
    end else if (!accept && pop) begin
      count_next = count_reg - CNTW'(1);
    end

    // The head register is the registered read port of the buffer.
    head_next = sym_data_reg;
    if (pop) begin
      if (count_reg == CNTW'(1)) begin
        if (accept) begin
          head_next = push_data;
        end
      end else begin
        head_next = mem[rd_ptr_inc];
      end
    end else if (count_reg == '0 && accept) begin
      head_next = push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      count_reg     <= '0;
      sym_valid_reg <= 1'b0;
      sym_data_reg  <= '0;
      overflow_reg  <= 1'b0;
    end else begin
      if (accept) begin
        wr_ptr_reg <= wr_ptr_reg + PW'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_inc;
      end
      count_reg     <= count_next;
      sym_valid_reg <= (count_next != '0);
      sym_data_reg  <= head_next;
      overflow_reg  <= overflow_reg | drop;
    end
  end

endmodule

// File: tb/tb_pattern_input_conditioner.sv
// Directed bench for pattern_input_conditioner with DEBOUNCE_CYCLES=4, FIFO_DEPTH=4.
// A raw change applied just after an edge is pushed on the 6th edge that follows.
module tb_pattern_input_conditioner;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] raw_i = 4'b0000;
  logic       sym_ready = 1'b1;
  logic       sym_valid;
  logic [3:0] sym_data;
  logic [2:0] fifo_count;
  logic       overflow;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pattern_input_conditioner #(
    .DEBOUNCE_CYCLES(4),
    .FIFO_DEPTH(4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .raw_i      (raw_i),
    .sym_ready  (sym_ready),
    .sym_valid  (sym_valid),
    .sym_data   (sym_data),
    .fifo_count (fifo_count),
    .overflow   (overflow)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Apply a raw level and run up to and including its push edge.
  task automatic settle(input logic [3:0] v);
    raw_i = v;
    repeat (6) tick();
  endtask

  initial begin
    // Reset state
    repeat (2) tick();
    reset = 1'b0;
    chk("rst_valid", sym_valid, 0);
    chk("rst_count", fifo_count, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_data", sym_data, 0);

    // Single bit debounce: push on edge k+5, popped one edge later
    raw_i = 4'b0001;
    repeat (5) tick();
    chk("first_not_yet", sym_valid, 0);
    tick();
    chk("first_valid", sym_valid, 1);
    chk("first_data", sym_data, 4'b0001);
    chk("first_count", fifo_count, 1);
    tick();
    chk("first_popped", sym_valid, 0);
    repeat (4) tick();
    chk("first_only_one", fifo_count, 0);

    // 3-cycle glitch on bit2 is filtered
    raw_i = 4'b0101;
    repeat (3) tick();
    raw_i = 4'b0001;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("glitch_count", fifo_count, 0);
    end

    // Simultaneous bit changes merge into one symbol
    settle(4'b0100);
    chk("merge_a_data", sym_data, 4'b0100);
    chk("merge_a_valid", sym_valid, 1);
    tick();
    settle(4'b1001);
    chk("merge_b_data", sym_data, 4'b1001);
    chk("merge_b_count", fifo_count, 1);
    tick();
    chk("merge_b_drained", fifo_count, 0);
    repeat (3) tick();
    chk("merge_b_single", sym_valid, 0);

    // Back-pressure: five symbols, the fifth dropped
    sym_ready = 1'b0;
    settle(4'b0011);
    chk("bp_count1", fifo_count, 1);
    settle(4'b0111);
    chk("bp_count2", fifo_count, 2);
    chk("bp_hold", sym_data, 4'b0011);
    settle(4'b1111);
    chk("bp_count3", fifo_count, 3);
    settle(4'b1110);
    chk("bp_count4", fifo_count, 4);
    chk("bp_ovf_clear", overflow, 0);
    settle(4'b1100);
    chk("bp_count_full", fifo_count, 4);
    chk("bp_ovf_set", overflow, 1);
    chk("bp_head_held", sym_data, 4'b0011);
    sym_ready = 1'b1;
    chk("bp_out0", sym_data, 4'b0011);
    tick();
    chk("bp_out1", sym_data, 4'b0111);
    tick();
    chk("bp_out2", sym_data, 4'b1111);
    tick();
    chk("bp_out3", sym_data, 4'b1110);
    tick();
    chk("bp_empty", sym_valid, 0);
    chk("bp_ovf_sticky", overflow, 1);

    // Reset mid-operation discards buffered symbols and partial counts
    sym_ready = 1'b0;
    settle(4'b1000);
    settle(4'b0000);
    chk("mid_count2", fifo_count, 2);
    raw_i = 4'b0010;
    repeat (3) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid_valid", sym_valid, 0);
    chk("mid_count", fifo_count, 0);
    chk("mid_ovf", overflow, 0);
    repeat (5) tick();
    chk("mid_not_yet", sym_valid, 0);
    tick();
    chk("mid_new_valid", sym_valid, 1);
    chk("mid_new_data", sym_data, 4'b0010);
    chk("mid_new_count", fifo_count, 1);

    // Full buffer with push and pop on the same edge
    settle(4'b0110);
    settle(4'b0111);
    settle(4'b0101);
    chk("fp_full", fifo_count, 4);
    raw_i = 4'b0100;
    repeat (5) tick();
    sym_ready = 1'b1;
    tick();
    chk("fp_count", fifo_count, 4);
    chk("fp_ovf", overflow, 0);
    chk("fp_head", sym_data, 4'b0110);
    tick();
    chk("fp_out1", sym_data, 4'b0111);
    tick();
    chk("fp_out2", sym_data, 4'b0101);
    tick();
    chk("fp_out3", sym_data, 4'b0100);
    tick();
    chk("fp_empty", sym_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pattern_input_conditioner.md
PATTERN_INPUT_CONDITIONER -- requirements
Module: pattern_input_conditioner

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 4, meaning consecutive mismatching cycles needed to accept a new input level; legal range 2..255.
REQ-002 Parameter FIFO_DEPTH, default 4, meaning symbol buffer entries; power of two, at least 2.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 reset  input  1  reset, synchronous, active-high.
REQ-005 raw_i  input  4  asynchronous raw pattern inputs; bit0=i1, bit1=i2, bit2=i3, bit3=i4.
REQ-006 sym_ready  input  1  downstream sequence detector accepts the head symbol.
REQ-007 sym_valid  output  1  head symbol available.
REQ-008 sym_data  output  4  head symbol (debounced input vector), same bit mapping as raw_i.
REQ-009 fifo_count  output  $clog2(FIFO_DEPTH+1)  number of buffered symbols, 0..FIFO_DEPTH.
REQ-010 overflow  output  1  sticky flag: a symbol was dropped because the buffer was full.

Function
REQ-011 Each raw_i bit SHALL pass through a 2-flop synchronizer; sync2 holds the raw value sampled two edges earlier.
REQ-012 Each bit SHALL have a stable register and a mismatch counter of width $clog2(DEBOUNCE_CYCLES).
REQ-013 On an edge where sync2 equals stable, the counter SHALL clear to 0.
REQ-014 On an edge where sync2 differs from stable and counter < DEBOUNCE_CYCLES-1, the counter SHALL increment.
REQ-015 On an edge where sync2 differs from stable and counter == DEBOUNCE_CYCLES-1, stable SHALL take sync2 and the counter SHALL clear; this is an update event for that bit.
REQ-016 A raw change set up before edge k and held SHALL be visible in the stable vector after edge k+1+DEBOUNCE_CYCLES.
REQ-017 A raw pulse or glitch that lasts fewer than DEBOUNCE_CYCLES cycles after synchronization SHALL NOT change the stable vector.
REQ-018 On any edge with at least one update event, exactly one symbol SHALL be pushed, equal to the new stable vector; simultaneous bit updates SHALL merge into one symbol.
REQ-019 The buffer SHALL be first-word-fall-through: sym_valid = (fifo_count != 0) and sym_data = head entry, both driven from registers.
REQ-020 A pop SHALL occur on an edge where sym_valid && sym_ready.
REQ-021 While sym_valid && !sym_ready, sym_data SHALL hold its value.
REQ-022 A push into an empty buffer SHALL raise sym_valid after the same edge; there is no same-cycle bypass.
REQ-023 Push and pop on the same edge SHALL leave fifo_count unchanged; this applies when full as well, and the push is accepted.
REQ-024 A push when full without a pop SHALL drop the new symbol, leave the buffer unchanged, and set overflow.
REQ-025 overflow SHALL stay set until reset.
REQ-026 Read and write pointers SHALL wrap modulo FIFO_DEPTH; symbols SHALL leave in push order.

Reset
REQ-027 While reset is high at an edge, the following SHALL clear to 0: sync flops, stable vectors, counters, pointers, fifo_count, sym_valid, sym_data and overflow.
REQ-028 Reset mid-operation SHALL discard all buffered symbols and partial debounce counts.
REQ-029 After reset, a raw level that is still non-zero SHALL debounce afresh from stable=0 and emit a symbol per REQ-016.
REQ-030 No symbol SHALL be emitted for the reset value itself.

Structure
REQ-031 Shared package pattern_pkg SHALL hold NUM_INPUTS=4, the bit-index constants SYM_I1..SYM_I4, and the symbol typedef (4-bit vector).
REQ-032 Per-bit synchronizer and debouncer SHALL be sub-module debounce_bit, instantiated NUM_INPUTS times.
REQ-033 The FIFO and the merge logic SHALL reside in the top module.

Verification (DEBOUNCE_CYCLES=4, FIFO_DEPTH=4)
REQ-034 Reset, then raw_i=0001 held from before edge k with sym_ready=1 -> sym_valid=1 and sym_data=0001 after edge k+5, deasserting one cycle later; exactly one symbol.
REQ-035 raw_i bit2 high for 3 cycles then low -> no symbol, fifo_count stays 0.
REQ-036 Stable 0100, then raw_i=1001 applied in one cycle -> exactly one symbol 1001.
REQ-037 sym_ready=0 with 5 distinct debounced changes -> fifo_count=4 and overflow=1 after the 5th; then sym_ready=1 -> the first 4 symbols emerge in order, and overflow stays 1.
REQ-038 Buffer full, with a push and sym_ready=1 on the same edge -> fifo_count stays 4, overflow stays 0, and the new symbol is last in order.
REQ-039 fifo_count=2 with a debounce in progress, then reset for 1 cycle -> sym_valid=0, fifo_count=0 and overflow=0 the next cycle; the held raw level yields one new symbol 5 edges after reset is released.
